main_mem_ctrl: RTL and testbench

//  Synthesizable backing-memory controller directly downstream of the L2 cache (top's *_L2_MEM ports).

---
 rtl/mem_pkg.sv | 28 ++
 rtl/main_mem_ctrl_if.sv | 27 ++
 rtl/mem_line_array.sv | 56 +++++
 rtl/main_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_main_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM state type and default line pattern for main_mem_ctrl
package mem_pkg;

  localparam int LINE_W  = 512;
  localparam int TAG_W   = 18;
  localparam int IDX_W   = 8;
  localparam int LADDR_W = 26;
  localparam int WORDS   = LINE_W / 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BUSY = 3'd1,
    RD_BUSY = 3'd2,
    RESP    = 3'd3,
    GAP     = 3'd4
  } state_t;

  // Word k of an unwritten line is {line_addr, k, 2'b00}
  function automatic logic [LINE_W-1:0] default_line(input logic [LADDR_W-1:0] line_addr);
    logic [LINE_W-1:0] line;
    line = '0;
    for (int k = 0; k < WORDS; k++) begin
      line[32*k +: 32] = {line_addr, k[3:0], 2'b00};
    end
    return line;
  endfunction

endpackage

// File: rtl/main_mem_ctrl_if.sv
// rtl/main_mem_ctrl_if.sv - L2 <-> backing memory request/response bundle
interface main_mem_ctrl_if;
  import mem_pkg::*;

  logic              read_L2_MEM;
  logic              write_L2_MEM;
  logic [IDX_W-1:0]  index_L2_MEM;
  logic [TAG_W-1:0]  tag_L2_MEM;
  logic [TAG_W-1:0]  write_tag_L2_MEM;
  logic [LINE_W-1:0] write_data_L2_MEM;
  logic              ready_MEM_L2;
  logic [LINE_W-1:0] read_data_MEM_L2;
  logic              busy;

  modport master (
    output read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    input  ready_MEM_L2, read_data_MEM_L2, busy
  );

  modport slave (
    input  read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    output ready_MEM_L2, read_data_MEM_L2, busy
  );

endinterface

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - direct-mapped line store with per-slot address tag and resettable valid bits
module mem_line_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LG = 10
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               we,
  input  logic [LADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0]  wdata,
  input  logic [LADDR_W-1:0] raddr,
  output logic [LINE_W-1:0]  rdata,
  output logic               hit
);

  localparam int DEPTH = 1 << DEPTH_LG;

  logic [LINE_W-1:0]  line_data_q [DEPTH];
  logic [LADDR_W-1:0] line_addr_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;

  logic [DEPTH_LG-1:0] wslot;
  logic [DEPTH_LG-1:0] rslot;

  assign wslot = waddr[DEPTH_LG-1:0];
  assign rslot = raddr[DEPTH_LG-1:0];

  // Payload storage is not reset; only the valid vector is
  always_ff @(posedge clk) begin
    if (we) begin
      line_data_q[wslot] <= wdata;
      line_addr_q[wslot] <= waddr;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (we) begin
      valid_d[wslot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign hit   = valid_q[rslot] && (line_addr_q[rslot] == raddr);
  assign rdata = line_data_q[rslot];

endmodule

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - fixed-latency backing memory controller serving L2 line reads and writebacks
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int LAT_RD   = 16,
  parameter int LAT_WR   = 8,
  parameter int DEPTH_LG = 10
) (
  input  logic            clk,
  input  logic            nrst,
  main_mem_ctrl_if.slave  bus
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(LAT_RD - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(LAT_WR - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_rd_q, cap_rd_d;
  logic [LADDR_W-1:0] cap_raddr_q, cap_raddr_d;
  logic [LADDR_W-1:0] cap_waddr_q, cap_waddr_d;
  logic [LINE_W-1:0]  cap_wdata_q, cap_wdata_d;
  logic               ready_q, ready_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;

  logic               mem_we;
  logic [LINE_W-1:0]  arr_rdata;
  logic               arr_hit;

  mem_line_array #(
    .DEPTH_LG (DEPTH_LG)
  ) u_array (
    .clk   (clk),
    .nrst  (nrst),
    .we    (mem_we),
    .waddr (cap_waddr_q),
    .wdata (cap_wdata_q),
    .raddr (cap_raddr_q),
    .rdata (arr_rdata),
    .hit   (arr_hit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_rd_d    = cap_rd_q;
    cap_raddr_d = cap_raddr_q;
    cap_waddr_d = cap_waddr_q;
    cap_wdata_d = cap_wdata_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        // if-tests rather than copies so an unknown request reads as 0
        if (bus.read_L2_MEM || bus.write_L2_MEM) begin
          cap_rd_d    = 1'b0;
          if (bus.read_L2_MEM) begin
            cap_rd_d = 1'b1;
          end
          cap_raddr_d = {bus.tag_L2_MEM, bus.index_L2_MEM};
          cap_waddr_d = {bus.write_tag_L2_MEM, bus.index_L2_MEM};
          cap_wdata_d = bus.write_data_L2_MEM;
          if (bus.write_L2_MEM) begin
            state_d = WR_BUSY;
            cnt_d   = WR_INIT;
          end else begin
            state_d = RD_BUSY;
            cnt_d   = RD_INIT;
          end
        end
      end
      WR_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          mem_we = 1'b1;
          if (cap_rd_q) begin
            state_d = RD_BUSY;
            cnt_d   = RD_INIT;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
            ready_d = 1'b1;
          end
        end
      end
      RD_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          rdata_d = arr_hit ? arr_rdata : default_line(cap_raddr_q);
          state_d = RESP;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_rd_q    <= 1'b0;
      cap_raddr_q <= '0;
      cap_waddr_q <= '0;
      cap_wdata_q <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_rd_q    <= cap_rd_d;
      cap_raddr_q <= cap_raddr_d;
      cap_waddr_q <= cap_waddr_d;
      cap_wdata_q <= cap_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.ready_MEM_L2     = ready_q;
  assign bus.read_data_MEM_L2 = rdata_q;
  assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - self-checking bench for main_mem_ctrl
module tb_main_mem_ctrl;

  localparam int LAT_RD   = 16;
  localparam int LAT_WR   = 8;
  localparam int DEPTH_LG = 10;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  main_mem_ctrl_if bus_if ();

  main_mem_ctrl #(
    .LAT_RD   (LAT_RD),
    .LAT_WR   (LAT_WR),
    .DEPTH_LG (DEPTH_LG)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [17:0]  tag;
    logic [17:0]  wtag;
    logic [7:0]   idx;
    logic [511:0] wd;
    int           exp_lat;
    logic [511:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  // Reference store keyed by full line address; a write evicts any line sharing its slot
  logic [511:0] store [logic [25:0]];

  function automatic logic [511:0] def_line(input logic [25:0] la);
    logic [511:0] l;
    logic [31:0]  base;
    base = {6'b0, la} * 32'd64;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k * 4);
    return l;
  endfunction

  function automatic void model_write(input logic [25:0] la, input logic [511:0] d);
    logic [25:0] victims[$];
    foreach (store[a]) if (a[DEPTH_LG-1:0] == la[DEPTH_LG-1:0]) victims.push_back(a);
    foreach (victims[i]) store.delete(victims[i]);
    store[la] = d;
  endfunction

  function automatic logic [511:0] model_read(input logic [25:0] la);
    if (store.exists(la)) return store[la];
    return def_line(la);
  endfunction

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [17:0] tag,
                               input logic [17:0] wtag, input logic [7:0] idx,
                               input logic [511:0] wd, input int lat, input logic [511:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.tag = tag; v.wtag = wtag; v.idx = idx;
    v.wd = wd; v.exp_lat = lat; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus_if.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk_int("wait_idle_timeout", int'(bus_if.busy), 0);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic rd, input logic wr, input logic [17:0] tag,
                         input logic [17:0] wtag, input logic [7:0] idx,
                         input logic [511:0] wd, output int lat, output logic [511:0] rdat);
    wait_idle();
    bus_if.read_L2_MEM       = rd;
    bus_if.write_L2_MEM      = wr;
    bus_if.tag_L2_MEM        = tag;
    bus_if.write_tag_L2_MEM  = wtag;
    bus_if.index_L2_MEM      = idx;
    bus_if.write_data_L2_MEM = wd;
    lat  = -1;
    rdat = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.ready_MEM_L2) begin
        lat  = i;
        rdat = bus_if.read_data_MEM_L2;
        break;
      end
    end
    bus_if.read_L2_MEM  = 1'b0;
    bus_if.write_L2_MEM = 1'b0;
    @(posedge clk);
    #1;
    chk_int("single_pulse", int'(bus_if.ready_MEM_L2), 0);
  endtask

  logic [511:0] C_DEAD, C_D, C_E1, C_E2, C_F, last_rd, rdat, wd, exp;
  logic [17:0]  tag, wtag;
  logic [7:0]   idx;
  logic         rd, wr, prev;
  int           lat, exp_lat, pulses, last_pulse, min_gap, dbl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus_if.read_L2_MEM       = 1'b0;
    bus_if.write_L2_MEM      = 1'b0;
    bus_if.tag_L2_MEM        = '0;
    bus_if.write_tag_L2_MEM  = '0;
    bus_if.index_L2_MEM      = '0;
    bus_if.write_data_L2_MEM = '0;

    C_DEAD = {16{32'hDEADBEEF}};
    C_D    = {16{32'hC0FFEE00}};
    C_E1   = {16{32'h11111111}};
    C_E2   = {16{32'h22222222}};
    C_F    = {16{32'hF00DF00D}};

    vecs[0] = mkv(1, 0, 18'h1, 18'h0, 8'h05, '0,     LAT_RD + 1,          def_line(26'h000105));
    vecs[1] = mkv(0, 1, 18'h0, 18'h2, 8'h05, C_DEAD, LAT_WR + 1,          def_line(26'h000105));
    vecs[2] = mkv(1, 0, 18'h2, 18'h0, 8'h05, '0,     LAT_RD + 1,          C_DEAD);
    vecs[3] = mkv(1, 1, 18'h7, 18'h3, 8'h10, C_D,    LAT_WR + LAT_RD + 1, def_line(26'h000710));
    vecs[4] = mkv(1, 0, 18'h3, 18'h0, 8'h10, '0,     LAT_RD + 1,          C_D);
    vecs[5] = mkv(0, 1, 18'h0, 18'h4, 8'h00, C_E1,   LAT_WR + 1,          C_D);
    vecs[6] = mkv(0, 1, 18'h0, 18'h8, 8'h00, C_E2,   LAT_WR + 1,          C_D);
    vecs[7] = mkv(1, 0, 18'h4, 18'h0, 8'h00, '0,     LAT_RD + 1,          def_line(26'h000400));
    vecs[8] = mkv(1, 0, 18'h8, 18'h0, 8'h00, '0,     LAT_RD + 1,          C_E2);
    vecs[9] = mkv(1, 1, 18'h9, 18'h9, 8'h22, C_F,    LAT_WR + LAT_RD + 1, C_F);

    repeat (3) @(negedge clk);
    chk("rst_ready", {511'b0, bus_if.ready_MEM_L2}, '0);
    chk("rst_rdata", bus_if.read_data_MEM_L2, '0);
    chk("rst_busy", {511'b0, bus_if.busy}, '0);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {511'b0, bus_if.busy}, '0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].tag, vecs[i].wtag, vecs[i].idx, vecs[i].wd, lat, rdat);
      if (vecs[i].wr) model_write({vecs[i].wtag, vecs[i].idx}, vecs[i].wd);
      chk_int($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rd);
    end
    last_rd = C_F;

    // Read held high across RESP/GAP: each pass must be a fresh request with one pulse
    wait_idle();
    bus_if.tag_L2_MEM   = 18'h5;
    bus_if.index_L2_MEM = 8'h01;
    bus_if.read_L2_MEM  = 1'b1;
    pulses = 0; last_pulse = -1; min_gap = 1000; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.ready_MEM_L2) begin
        if (prev) dbl++;
        if (last_pulse >= 0 && (i - last_pulse) < min_gap) min_gap = i - last_pulse;
        last_pulse = i;
        pulses++;
        chk("held_rdata", bus_if.read_data_MEM_L2, model_read(26'h000501));
      end
      prev = bus_if.ready_MEM_L2;
    end
    bus_if.read_L2_MEM = 1'b0;
    chk_int("held_pulses", pulses, 4);
    chk_int("held_double", dbl, 0);
    chk_int("held_min_gap_ok", int'(min_gap >= LAT_RD + 2), 1);
    last_rd = model_read(26'h000501);

    // Reset during WR_BUSY discards the in-flight write and clears all valid bits
    wait_idle();
    bus_if.write_tag_L2_MEM  = 18'h0A;
    bus_if.index_L2_MEM      = 8'h33;
    bus_if.write_data_L2_MEM = C_DEAD;
    bus_if.write_L2_MEM      = 1'b1;
    repeat (4) @(negedge clk);
    chk("midop_busy_before", {511'b0, bus_if.busy}, {511'b0, 1'b1});
    nrst = 1'b0;
    bus_if.write_L2_MEM = 1'b0;
    #1;
    chk("midop_rst_busy", {511'b0, bus_if.busy}, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midop_rst_ready", {511'b0, bus_if.ready_MEM_L2}, '0);
    end
    chk("midop_rst_rdata", bus_if.read_data_MEM_L2, '0);
    @(negedge clk);
    nrst = 1'b1;
    store.delete();
    last_rd = '0;
    run_txn(1, 0, 18'h0A, 18'h0, 8'h33, '0, lat, rdat);
    chk_int("midop_read_lat", lat, LAT_RD + 1);
    chk("midop_read_default", rdat, def_line(26'h000A33));
    run_txn(1, 0, 18'h8, 18'h0, 8'h00, '0, lat, rdat);
    chk("midop_valid_cleared", rdat, def_line(26'h000800));
    last_rd = rdat;

    // Randomized traffic on a small address range to provoke hits, misses and aliasing
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      tag  = 18'($urandom_range(0, 7) << 2);
      wtag = 18'($urandom_range(0, 7) << 2);
      idx  = 8'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
      exp_lat = wr ? (rd ? LAT_WR + LAT_RD + 1 : LAT_WR + 1) : LAT_RD + 1;
      if (wr) model_write({wtag, idx}, wd);
      exp = rd ? model_read({tag, idx}) : last_rd;
      run_txn(rd, wr, tag, wtag, idx, wd, lat, rdat);
      chk_int($sformatf("rand%0d_lat", n), lat, exp_lat);
      chk($sformatf("rand%0d_rdata", n), rdat, exp);
      last_rd = exp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
